// File: rtl/alu_mc.sv
// +------------------------------------------------------------------+
// | alu_mc : multi-cycle signed ALU (ADD/SUB/shift-add MUL/PASS)     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module alu_mc #(
  parameter int N        = 8,
  parameter int FRAC_MUL = 1,
  parameter int SAT      = 1
) (
  input  logic         clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [1:0]   Op,
  input  logic [N-1:0] DataA,
  input  logic [N-1:0] DataB,
  output logic [N-1:0] Result,
  output logic         Busy,
  output logic         Done,
  output logic         Zero,
  output logic         Neg,
  output logic         Ovf
);

  typedef enum logic [0:0] {IDLE = 1'b0, MUL_RUN = 1'b1} state_t;

  localparam logic [1:0]   c_OP_ADD  = 2'b00;
  localparam logic [1:0]   c_OP_SUB  = 2'b01;
  localparam logic [1:0]   c_OP_MUL  = 2'b10;
  localparam int           c_CW      = $clog2(N);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(N - 1);
  localparam logic [N-1:0] c_MAX     = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] c_MIN     = {1'b1, {(N-1){1'b0}}};

  state_t            r_state, w_state_next;
  logic [2*N-1:0]    r_mcand, r_acc, w_pp, w_acc_next;
  logic [N-1:0]      r_mplier;
  logic [c_CW-1:0]   r_cnt;
  logic              w_issue, w_last, w_wr;
  logic [N:0]        w_a_ext, w_b_ext, w_sum;
  logic [N-1:0]      w_mul_field, w_raw, w_final;
  logic              w_mul_ovf, w_ovf, w_sign;

  assign w_issue = (r_state == IDLE) && Start;
  assign w_last  = (r_state == MUL_RUN) && (r_cnt == c_LAST);
  assign w_wr    = (w_issue && (Op != c_OP_MUL)) || w_last;
  assign Busy    = (r_state == MUL_RUN);

  // The multiplier's MSB carries negative weight, so the final step subtracts.
  assign w_pp       = r_mplier[0] ? r_mcand : '0;
  assign w_acc_next = w_last ? (r_acc - w_pp) : (r_acc + w_pp);

  generate
    if (FRAC_MUL != 0) begin : g_frac
      assign w_mul_field = w_acc_next[2*N-2:N-1];
      assign w_mul_ovf   = w_acc_next[2*N-1] ^ w_acc_next[2*N-2];
    end else begin : g_int
      assign w_mul_field = w_acc_next[N-1:0];
      assign w_mul_ovf   = (w_acc_next[2*N-1:N-1] != {(N+1){w_acc_next[N-1]}});
    end
  endgenerate

  assign w_a_ext = {DataA[N-1], DataA};
  assign w_b_ext = {DataB[N-1], DataB};
  assign w_sum   = (Op == c_OP_SUB) ? (w_a_ext - w_b_ext) : (w_a_ext + w_b_ext);

  always_comb begin
    w_raw   = DataA;
    w_ovf   = 1'b0;
    w_sign  = DataA[N-1];
    w_final = '0;
    if (w_last) begin
      w_raw  = w_mul_field;
      w_ovf  = w_mul_ovf;
      w_sign = w_acc_next[2*N-1];
    end else if ((Op == c_OP_ADD) || (Op == c_OP_SUB)) begin
      w_raw  = w_sum[N-1:0];
      w_ovf  = w_sum[N] ^ w_sum[N-1];
      w_sign = w_sum[N];
    end
    if ((SAT != 0) && w_ovf) w_final = w_sign ? c_MIN : c_MAX;
    else                     w_final = w_raw;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (Start && (Op == c_OP_MUL)) w_state_next = MUL_RUN;
      MUL_RUN: if (w_last) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      Result   <= '0;
      Done     <= 1'b0;
      Zero     <= 1'b0;
      Neg      <= 1'b0;
      Ovf      <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else begin
      Done <= w_wr;
      if (w_wr) begin
        Result <= w_final;
        Zero   <= (w_final == '0);
        Neg    <= w_final[N-1];
        Ovf    <= w_ovf;
      end
      if (w_issue && (Op == c_OP_MUL)) begin
        r_mcand  <= {{N{DataA[N-1]}}, DataA};
        r_mplier <= DataB;
        r_acc    <= '0;
        r_cnt    <= '0;
      end else if (r_state == MUL_RUN) begin
        r_acc    <= w_acc_next;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
